intr_ctrl: RTL and testbench

Parametrised multi-channel interrupt controller for the game CPU core, generalising the single `irr`/`intr_en`/`ack` interrupt path to `N_CH` prioritised sources. It sits between peripheral interrupt sources (UART RX/TX, timers, buttons) and the CPU's execute stage. It latches source edges into pending bits and applies an enable mask and the CPU's global enable. It raises a single request with a handler vector, saves the return PC on acceptance, and tracks the in-service channel until the handler acknowledges completion. One level of service at a time (no nesting).

---
 rtl/intr_ctrl.sv | 103 ++++++++++
 tb/tb_intr_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Multi-channel prioritised interrupt controller: edge-latched pending bits, enable mask,
// single-level service tracking with saved return PC and per-channel handler vector.
module intr_ctrl #(
    parameter int unsigned           N_CH       = 4,
    parameter int unsigned           PC_W       = 32,
    parameter logic [PC_W-1:0]       VEC_BASE   = PC_W'(32'h0000_0010),
    parameter int unsigned           VEC_STRIDE = 4,
    localparam int unsigned          CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] irq_src,
    input  logic            mask_we,
    input  logic [N_CH-1:0] mask_wdata,
    input  logic            intr_en,
    input  logic [PC_W-1:0] cur_pc,
    input  logic            take,
    input  logic            ack,
    output logic            irr,
    output logic [PC_W-1:0] vec_pc,
    output logic [PC_W-1:0] ret_pc,
    output logic            in_service,
    output logic [CH_W-1:0] active_ch,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] mask
);

    typedef enum logic {IDLE, SERVICE} state_t;

    state_t          state_q, state_d;
    logic [N_CH-1:0] src_q;
    logic [N_CH-1:0] pending_q;
    logic [N_CH-1:0] mask_q;
    logic [PC_W-1:0] ret_pc_q;
    logic [CH_W-1:0] active_ch_q;

    logic [N_CH-1:0] elig;
    logic [N_CH-1:0] src_edge;
    logic [N_CH-1:0] clr;
    logic [CH_W-1:0] sel;
    logic            accept;

    assign elig     = pending_q & mask_q;
    assign src_edge = irq_src & ~src_q;

    // Lowest index wins: scan downward so the last hit is the highest-priority channel.
    always_comb begin
        sel = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (elig[i]) sel = CH_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        irr     = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                irr = intr_en & (|elig);
                if (take && irr) begin
                    accept  = 1'b1;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr    = accept ? (N_CH'(1) << sel) : '0;
    assign vec_pc = VEC_BASE + PC_W'(sel) * PC_W'(VEC_STRIDE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            ret_pc_q    <= '0;
            active_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= irq_src;
            // A fresh edge on a channel being cleared this cycle keeps it pending.
            pending_q <= (pending_q & ~clr) | src_edge;
            if (mask_we) mask_q <= mask_wdata;
            if (accept) begin
                ret_pc_q    <= cur_pc;
                active_ch_q <= sel;
            end
        end
    end

    assign in_service = (state_q == SERVICE);
    assign ret_pc     = ret_pc_q;
    assign active_ch  = active_ch_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with literal expectations plus randomized traffic,
// all outputs compared every cycle against a behavioural model of the controller.
module tb_intr_ctrl;

    localparam logic [31:0] VB = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  irq_src, mask_wdata;
    logic        mask_we, intr_en, take, ack;
    logic [31:0] cur_pc;
    logic        irr, in_service;
    logic [31:0] vec_pc, ret_pc;
    logic [1:0]  active_ch;
    logic [3:0]  pending, mask;

    intr_ctrl #(.N_CH(4), .PC_W(32), .VEC_BASE(32'h10), .VEC_STRIDE(4)) dut (
        .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .intr_en(intr_en), .cur_pc(cur_pc), .take(take),
        .ack(ack), .irr(irr), .vec_pc(vec_pc), .ret_pc(ret_pc),
        .in_service(in_service), .active_ch(active_ch), .pending(pending), .mask(mask)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit [3:0]  m_pend, m_prev, m_mask;
    bit        m_svc;
    bit [31:0] m_ret;
    int        m_ch;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int lowest(bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit exp_irr();
        return !m_svc && (intr_en === 1'b1) && ((m_pend & m_mask) != 4'b0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_mask = '0; m_svc = 1'b0; m_ret = '0; m_ch = 0;
    endtask

    task automatic check_all();
        chk("irr", {31'b0, irr}, {31'b0, exp_irr()});
        chk("in_service", {31'b0, in_service}, {31'b0, m_svc});
        chk("pending", {28'b0, pending}, {28'b0, m_pend});
        chk("mask", {28'b0, mask}, {28'b0, m_mask});
        chk("ret_pc", ret_pc, m_ret);
        chk("active_ch", {30'b0, active_ch}, 32'(m_ch));
        if (exp_irr() || (m_pend & m_mask) == 4'b0)
            chk("vec_pc", vec_pc, VB + 32'(lowest(m_pend & m_mask)) * 32'd4);
    endtask

    // One clock: compare before the edge, then advance the model with the inputs the DUT samples.
    task automatic cycle();
        bit acc;
        bit [3:0] edges;
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            acc   = take && exp_irr();
            edges = irq_src & ~m_prev;
            if (acc) begin
                m_ret = cur_pc;
                m_ch  = lowest(m_pend & m_mask);
                m_pend[m_ch] = 1'b0;
                m_svc = 1'b1;
            end else if (m_svc && ack) begin
                m_svc = 1'b0;
            end
            m_pend = m_pend | edges;
            if (mask_we) m_mask = mask_wdata;
            m_prev = irq_src;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; irq_src = '0; mask_we = 1'b0; mask_wdata = '0;
        intr_en = 1'b0; take = 1'b0; ack = 1'b0; cur_pc = '0;
        model_reset();
        #1;
        chk("rst_irr", {31'b0, irr}, 32'd0);
        chk("rst_in_service", {31'b0, in_service}, 32'd0);
        chk("rst_vec_pc", vec_pc, 32'h10);
        chk("rst_pending", {28'b0, pending}, 32'd0);
        chk("rst_ret_pc", ret_pc, 32'd0);
        cycle(); cycle();
        rst_n = 1'b1;

        // Channel 2 pulse, accept, check saved state
        intr_en = 1'b1; mask_we = 1'b1; mask_wdata = 4'b1111; cycle(); mask_we = 1'b0;
        irq_src = 4'b0100; cycle(); irq_src = 4'b0000;
        chk("t1_irr", {31'b0, irr}, 32'd1);
        chk("t1_vec", vec_pc, 32'h18);
        take = 1'b1; cur_pc = 32'h100; cycle(); take = 1'b0;
        chk("t1_ret", ret_pc, 32'h100);
        chk("t1_ch", {30'b0, active_ch}, 32'd2);
        chk("t1_svc", {31'b0, in_service}, 32'd1);
        chk("t1_pend2", {31'b0, pending[2]}, 32'd0);
        chk("t1_irr0", {31'b0, irr}, 32'd0);
        ack = 1'b1; cycle(); ack = 1'b0;

        // Simultaneous edges on ch1 and ch3
        irq_src = 4'b1010; cycle(); irq_src = 4'b0000;
        chk("t2_vec1", vec_pc, 32'h14);
        take = 1'b1; cycle(); take = 1'b0;
        ack = 1'b1; cycle(); ack = 1'b0;
        chk("t2_irr", {31'b0, irr}, 32'd1);
        chk("t2_vec3", vec_pc, 32'h1C);
        take = 1'b1; cycle(); take = 1'b0;
        ack = 1'b1; cycle(); ack = 1'b0;

        // Masked pending, unmask, global disable
        mask_we = 1'b1; mask_wdata = 4'b0000; cycle(); mask_we = 1'b0;
        irq_src = 4'b0001; cycle(); irq_src = 4'b0000;
        chk("t3_pend", {28'b0, pending}, 32'h1);
        chk("t3_irr0", {31'b0, irr}, 32'd0);
        mask_we = 1'b1; mask_wdata = 4'b0001; cycle(); mask_we = 1'b0;
        chk("t3_irr1", {31'b0, irr}, 32'd1);
        intr_en = 1'b0; #1;
        chk("t3_dis_irr", {31'b0, irr}, 32'd0);
        chk("t3_dis_pend", {28'b0, pending}, 32'h1);
        intr_en = 1'b1;

        // New edges accumulate during service
        take = 1'b1; cur_pc = 32'h200; cycle(); take = 1'b0;
        ack = 1'b1; cycle(); ack = 1'b0;
        mask_we = 1'b1; mask_wdata = 4'b1111; cycle(); mask_we = 1'b0;
        irq_src = 4'b0100; cycle(); irq_src = 4'b0000;
        take = 1'b1; cycle(); take = 1'b0;
        chk("t4_ch", {30'b0, active_ch}, 32'd2);
        irq_src = 4'b0101; cycle(); irq_src = 4'b0000;
        chk("t4_irr", {31'b0, irr}, 32'd0);
        chk("t4_pend", {28'b0, pending}, 32'h5);
        ack = 1'b1; cycle(); ack = 1'b0;
        chk("t4_irr1", {31'b0, irr}, 32'd1);
        chk("t4_vec", vec_pc, 32'h10);

        // Edge racing the clear of its own channel; ignored take/ack
        take = 1'b1; cycle(); take = 1'b0; ack = 1'b1; cycle(); ack = 1'b0;
        take = 1'b1; cycle(); take = 1'b0; ack = 1'b1; cycle(); ack = 1'b0;
        irq_src = 4'b0010; cycle(); irq_src = 4'b0000; cycle();
        irq_src = 4'b0010; take = 1'b1; cur_pc = 32'h280; cycle(); take = 1'b0;
        chk("t5_pend1", {31'b0, pending[1]}, 32'd1);
        chk("t5_ch", {30'b0, active_ch}, 32'd1);
        ack = 1'b1; cycle(); ack = 1'b0;
        intr_en = 1'b0; take = 1'b1; cycle(); take = 1'b0; intr_en = 1'b1;
        chk("t5_take_ign", {31'b0, in_service}, 32'd0);
        ack = 1'b1; cycle(); ack = 1'b0;
        chk("t5_ack_ign", {31'b0, in_service}, 32'd0);
        chk("t5_ack_pend", {28'b0, pending}, 32'h2);

        // Asynchronous reset in the middle of service
        take = 1'b1; cur_pc = 32'h300; cycle(); take = 1'b0;
        irq_src = 4'b1000; cycle();
        chk("t6_svc", {31'b0, in_service}, 32'd1);
        #2 rst_n = 1'b0; #1;
        chk("t6_svc0", {31'b0, in_service}, 32'd0);
        chk("t6_irr0", {31'b0, irr}, 32'd0);
        chk("t6_pend0", {28'b0, pending}, 32'd0);
        chk("t6_mask0", {28'b0, mask}, 32'd0);
        chk("t6_ret0", ret_pc, 32'd0);
        model_reset();
        irq_src = 4'b0000; cycle();
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            irq_src    = irq_src ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            mask_we    = ($urandom_range(0, 9) == 0);
            mask_wdata = 4'($urandom_range(0, 15));
            intr_en    = ($urandom_range(0, 7) != 0);
            take       = ($urandom_range(0, 2) == 0);
            ack        = ($urandom_range(0, 3) == 0);
            cur_pc     = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
